// File: rtl/inert_pkg.sv
// Shared definitions for the inertial moving-average filter.
//   SAMPLE_W    : width of one signed inertial sample
//   avg_state_t : window fill state (IDLE -> FILL -> RUN)
//   sample_t    : one signed sample
package inert_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } avg_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/avg_axis.sv
// One axis of the boxcar filter: N-entry circular buffer, running sum and the
// divide-by-N shift, plus an optional deadband on the registered average.
// Optional feature macro: INERT_AVG_DEADBAND_EN (zero averages with |avg| < DEADBAND).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of sum and average
//   acc_i       : accept sample_i this edge (write buffer, update sum)
//   upd_i       : accepted sample completes/maintains a full window; load avg
//   full_i      : window already full, so the slot at wr_ptr_i holds the oldest sample
//   wr_ptr_i    : shared write pointer
//   sample_i    : incoming sample
//   avg_o       : registered window average
module avg_axis import inert_pkg::*; #(
  parameter int unsigned LOG2_N   = 2,
  parameter int unsigned DEADBAND = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       acc_i,
  input  logic                       upd_i,
  input  logic                       full_i,
  input  logic [LOG2_N-1:0]          wr_ptr_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [SAMPLE_W-1:0] avg_o
);

  localparam int unsigned N    = 2 ** LOG2_N;
  localparam int unsigned SumW = SAMPLE_W + LOG2_N;

  sample_t                mem_q [N];
  logic signed [SumW-1:0] sum_q, sum_d;
  logic signed [SumW-1:0] samp_ext, old_ext;
  sample_t                oldest;
  sample_t                avg_raw, avg_d, avg_q;

  always_comb begin
    oldest   = full_i ? mem_q[wr_ptr_i] : '0;
    samp_ext = {{LOG2_N{sample_i[SAMPLE_W-1]}}, sample_i};
    old_ext  = {{LOG2_N{oldest[SAMPLE_W-1]}}, oldest};
    sum_d    = sum_q + samp_ext - old_ext;
    // Top SAMPLE_W bits of the sum == sum >>> LOG2_N (floor); the window
    // average always fits in SAMPLE_W bits.
    avg_raw  = sum_d[SumW-1:LOG2_N];
  end

`ifdef INERT_AVG_DEADBAND_EN
  localparam logic [SAMPLE_W-2:0] DbThr = DEADBAND[SAMPLE_W-2:0];

  logic [SAMPLE_W-2:0] mag;

  always_comb begin
    avg_d = avg_raw;
    mag   = avg_raw[SAMPLE_W-1] ? (SAMPLE_W-1)'(-avg_raw) : avg_raw[SAMPLE_W-2:0];
    // -32768 has no positive twin; treat it as large.
    if ((avg_raw != {1'b1, {(SAMPLE_W-1){1'b0}}}) && (mag < DbThr)) begin
      avg_d = '0;
    end
  end
`else
  logic unused_deadband;
  assign unused_deadband = ^DEADBAND;

  always_comb begin
    avg_d = avg_raw;
  end
`endif

  // Buffer contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (acc_i) begin
      mem_q[wr_ptr_i] <= sample_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      avg_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
      avg_q <= '0;
    end else begin
      if (acc_i) begin
        sum_q <= sum_d;
      end
      if (upd_i) begin
        avg_q <= avg_d;
      end
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/inert_avg.sv
// Boxcar moving-average filter for the pitch/roll/yaw inertial stream.
// Owns the fill-state machine, sample count, shared write pointer, full flag
// and the output valid pulse; one avg_axis per axis does the arithmetic.
// Optional feature macro: INERT_AVG_DEADBAND_EN (see avg_axis).
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   clr                          : synchronous clear (calibration start); beats vld_in
//   vld_in                       : one-cycle new-sample strobe
//   ptch_in, roll_in, yaw_in     : signed samples
//   avg_vld                      : one-cycle pulse, averages updated
//   ptch_avg, roll_avg, yaw_avg  : signed window averages
//   full                         : window holds N samples since reset/clr
module inert_avg import inert_pkg::*; #(
  parameter int unsigned LOG2_N   = 2,
  parameter int unsigned DEADBAND = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       vld_in,
  input  logic signed [SAMPLE_W-1:0] ptch_in,
  input  logic signed [SAMPLE_W-1:0] roll_in,
  input  logic signed [SAMPLE_W-1:0] yaw_in,
  output logic                       avg_vld,
  output logic signed [SAMPLE_W-1:0] ptch_avg,
  output logic signed [SAMPLE_W-1:0] roll_avg,
  output logic signed [SAMPLE_W-1:0] yaw_avg,
  output logic                       full
);

  localparam int unsigned N    = 2 ** LOG2_N;
  localparam int unsigned PtrW = LOG2_N;
  localparam int unsigned CntW = LOG2_N + 1;

  avg_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic            full_q;
  logic            avg_vld_q;

  logic accept;
  logic last;
  logic upd;

  assign accept = vld_in & ~clr;
  // This sample is the N-th one since reset/clr.
  assign last   = (cnt_q == CntW'(N - 1));
  assign upd    = accept & (full_q | last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      full_q    <= 1'b0;
      avg_vld_q <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      full_q    <= 1'b0;
      avg_vld_q <= 1'b0;
    end else begin
      avg_vld_q <= upd;
      if (vld_in) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        unique case (state_q)
          IDLE: begin
            cnt_q   <= CntW'(1);
            state_q <= last ? RUN : FILL;
            full_q  <= last;
          end
          FILL: begin
            cnt_q <= cnt_q + CntW'(1);
            if (last) begin
              state_q <= RUN;
              full_q  <= 1'b1;
            end
          end
          RUN: begin
            full_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign full    = full_q;
  assign avg_vld = avg_vld_q;

  avg_axis #(
    .LOG2_N   (LOG2_N),
    .DEADBAND (DEADBAND)
  ) u_ptch (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .acc_i    (accept),
    .upd_i    (upd),
    .full_i   (full_q),
    .wr_ptr_i (wr_ptr_q),
    .sample_i (ptch_in),
    .avg_o    (ptch_avg)
  );

  avg_axis #(
    .LOG2_N   (LOG2_N),
    .DEADBAND (DEADBAND)
  ) u_roll (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .acc_i    (accept),
    .upd_i    (upd),
    .full_i   (full_q),
    .wr_ptr_i (wr_ptr_q),
    .sample_i (roll_in),
    .avg_o    (roll_avg)
  );

  avg_axis #(
    .LOG2_N   (LOG2_N),
    .DEADBAND (DEADBAND)
  ) u_yaw (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .acc_i    (accept),
    .upd_i    (upd),
    .full_i   (full_q),
    .wr_ptr_i (wr_ptr_q),
    .sample_i (yaw_in),
    .avg_o    (yaw_avg)
  );

endmodule
